// File: rtl/piso_serializer.sv
// Parallel-in/serial-out word serializer, MSB first, with a one-word hold
// register so back-to-back words stream with no idle bit between them.
module piso_serializer #(
  parameter int WIDTH = 7
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  output logic             din_ready,
  output logic             sout,
  output logic             sout_valid,
  output logic             sout_first,
  output logic             sout_last,
  output logic             busy
);

  // A 1-bit word still needs a 1-bit counter even though log2(1) is zero.
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t           state, state_nx;
  logic [WIDTH-1:0] shifter, shifter_nx;
  logic [CW-1:0]    cnt, cnt_nx;
  logic [WIDTH-1:0] hold, hold_nx;
  logic             hold_full, hold_full_nx;

  logic accept;
  logic in_shift;
  logic last_bit;

  assign in_shift  = (state == SHIFT);
  assign last_bit  = in_shift && (cnt == LAST);
  assign din_ready = rst & ~hold_full;
  assign accept    = din_valid & din_ready;

  assign sout       = in_shift & shifter[WIDTH-1];
  assign sout_valid = in_shift;
  assign sout_first = in_shift && (cnt == '0);
  assign sout_last  = last_bit;
  assign busy       = in_shift | hold_full;

  always_comb begin
    state_nx     = state;
    shifter_nx   = shifter;
    cnt_nx       = cnt;
    hold_nx      = hold;
    hold_full_nx = hold_full;
    case (state)
      IDLE: begin
        if (accept) begin
          shifter_nx = din;
          cnt_nx     = '0;
          state_nx   = SHIFT;
        end
      end
      SHIFT: begin
        shifter_nx = shifter << 1;
        cnt_nx     = cnt + CW'(1);
        if (last_bit) begin
          cnt_nx = '0;
          // Held word wins; a fresh word can only be accepted when hold is empty.
          if (hold_full) begin
            shifter_nx   = hold;
            hold_full_nx = 1'b0;
          end else if (accept) begin
            shifter_nx = din;
          end else begin
            state_nx = IDLE;
          end
        end else if (accept) begin
          hold_nx      = din;
          hold_full_nx = 1'b1;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      shifter   <= '0;
      cnt       <= '0;
      hold      <= '0;
      hold_full <= 1'b0;
    end else begin
      state     <= state_nx;
      shifter   <= shifter_nx;
      cnt       <= cnt_nx;
      hold      <= hold_nx;
      hold_full <= hold_full_nx;
    end
  end

endmodule

// File: tb/tb_piso_serializer.sv
// Bench for piso_serializer: cycle vector table, directed corner sequences and
// random traffic compared against a queue-of-words reference model.
module tb_piso_serializer;
  localparam int W = 7;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic [W-1:0] din = '0;
  logic         din_valid = 1'b0;
  logic         din_ready, sout, sout_valid, sout_first, sout_last, busy;

  int checks = 0;
  int errors = 0;

  piso_serializer #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .din(din), .din_valid(din_valid), .din_ready(din_ready),
    .sout(sout), .sout_valid(sout_valid), .sout_first(sout_first),
    .sout_last(sout_last), .busy(busy)
  );

  always #5 clk = ~clk;

  // Reference model: words accepted and not yet fully emitted, plus bit index
  // into the front word. Front word is on the wire; a second entry is the held one.
  logic [W-1:0] mq[$];
  int           mpos = 0;

  logic obs_sout, obs_valid, obs_first, obs_last, obs_busy, obs_ready;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Apply one cycle of inputs, compare against the model mid-cycle, then clock.
  task automatic step(input logic [W-1:0] d, input logic v);
    logic e_valid, e_sout;
    logic acc;
    din = d;
    din_valid = v;
    @(negedge clk);
    e_valid = (mq.size() > 0);
    e_sout  = e_valid ? mq[0][W-1-mpos] : 1'b0;
    obs_sout = sout; obs_valid = sout_valid; obs_first = sout_first;
    obs_last = sout_last; obs_busy = busy; obs_ready = din_ready;
    check("model_sout",  sout,       e_sout);
    check("model_valid", sout_valid, e_valid);
    check("model_first", sout_first, e_valid && mpos == 0);
    check("model_last",  sout_last,  e_valid && mpos == W-1);
    check("model_busy",  busy,       mq.size() > 0);
    check("model_ready", din_ready,  mq.size() < 2);
    acc = v && (mq.size() < 2);
    @(posedge clk);
    if (mq.size() > 0) begin
      mpos++;
      if (mpos == W) begin
        void'(mq.pop_front());
        mpos = 0;
      end
    end
    if (acc) mq.push_back(d);
    #1;
  endtask

  // Asynchronous reset pulse started mid-cycle; outputs must drop at once.
  task automatic do_reset(input string tag);
    #2;
    rst = 1'b0;
    din_valid = 1'b0;
    #1;
    check({tag, "_rst_sout"},  sout,       0);
    check({tag, "_rst_valid"}, sout_valid, 0);
    check({tag, "_rst_first"}, sout_first, 0);
    check({tag, "_rst_last"},  sout_last,  0);
    check({tag, "_rst_busy"},  busy,       0);
    check({tag, "_rst_ready"}, din_ready,  0);
    mq.delete();
    mpos = 0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic [W-1:0] d;
    logic         v;
    logic         so, sv, sf, sl, bz, rd;
  } vec_t;

  vec_t tbl[10];

  initial begin
    logic [W-1:0] words[4];
    logic [4*W-1:0] got, exp_cat;
    int k, nvalid, first_i, last_i, ready_low, gap, ready_ok;

    tbl[0] = '{7'b1011010, 1'b1, 0, 0, 0, 0, 0, 1};
    tbl[1] = '{7'b1111111, 1'b0, 1, 1, 1, 0, 1, 1};
    tbl[2] = '{7'b0000000, 1'b0, 0, 1, 0, 0, 1, 1};
    tbl[3] = '{7'b1111111, 1'b0, 1, 1, 0, 0, 1, 1};
    tbl[4] = '{7'b0000000, 1'b0, 1, 1, 0, 0, 1, 1};
    tbl[5] = '{7'b1111111, 1'b0, 0, 1, 0, 0, 1, 1};
    tbl[6] = '{7'b0000000, 1'b0, 1, 1, 0, 0, 1, 1};
    tbl[7] = '{7'b1111111, 1'b0, 0, 1, 0, 1, 1, 1};
    tbl[8] = '{7'b0000000, 1'b0, 0, 0, 0, 0, 0, 1};
    tbl[9] = '{7'b1111111, 1'b0, 0, 0, 0, 0, 0, 1};

    // Reset state
    #3;
    check("init_rst_ready", din_ready, 0);
    check("init_rst_valid", sout_valid, 0);
    check("init_rst_busy",  busy, 0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;

    // Single word, cycle by cycle
    for (int i = 0; i < 10; i++) begin
      step(tbl[i].d, tbl[i].v);
      check($sformatf("tbl%0d_sout", i),  obs_sout,  tbl[i].so);
      check($sformatf("tbl%0d_valid", i), obs_valid, tbl[i].sv);
      check($sformatf("tbl%0d_first", i), obs_first, tbl[i].sf);
      check($sformatf("tbl%0d_last", i),  obs_last,  tbl[i].sl);
      check($sformatf("tbl%0d_busy", i),  obs_busy,  tbl[i].bz);
      check($sformatf("tbl%0d_ready", i), obs_ready, tbl[i].rd);
    end

    // Back-to-back stream with din_valid held high
    words[0] = 7'b1011010; words[1] = 7'b1011011;
    words[2] = 7'b1011001; words[3] = 7'b1011000;
    exp_cat = {words[0], words[1], words[2], words[3]};
    k = 0; nvalid = 0; got = '0; first_i = -1; last_i = -1; ready_low = 0;
    for (int c = 0; c < 40; c++) begin
      step(k < 4 ? words[k] : 7'h55, k < 4);
      if (obs_valid) begin
        got = {got[4*W-2:0], obs_sout};
        nvalid++;
        if (first_i < 0) first_i = c;
        last_i = c;
      end
      if (!obs_ready) ready_low++;
      if (obs_ready && k < 4) k++;
    end
    check("stream_accepted", k, 4);
    check("stream_nbits", nvalid, 4*W);
    check("stream_contig", last_i - first_i + 1, 4*W);
    check("stream_bits", int'(got), int'(exp_cat));
    check("stream_hold_blocked", ready_low > 0, 1);

    // Bypass: second word offered only on the first word's last bit
    ready_ok = 1;
    step(7'b1100101, 1'b1);
    for (int i = 0; i < W-1; i++) begin
      step(7'h7f, 1'b0);
      if (!obs_ready) ready_ok = 0;
    end
    step(7'b0110011, 1'b1);
    check("bypass_on_last", obs_last, 1);
    if (!obs_ready) ready_ok = 0;
    step(7'h00, 1'b0);
    check("bypass_first", obs_first, 1);
    check("bypass_msb", obs_sout, 0);
    for (int i = 0; i < W-1; i++) begin
      step(7'h00, 1'b0);
      if (!obs_ready) ready_ok = 0;
    end
    check("bypass_hold_unused", ready_ok, 1);
    step(7'h00, 1'b0);
    check("bypass_idle", obs_busy, 0);

    // Held word is immune to din changes while din_ready is low
    step(7'b1000001, 1'b1);
    step(7'b0111110, 1'b1);
    for (int i = 0; i < 2*W + 2; i++) step(7'($urandom), 1'b1);
    for (int i = 0; i < 3*W; i++) step(7'($urandom), 1'b0);

    // Reset mid-word with a held word, then a fresh word from its MSB
    step(7'b1011010, 1'b1);
    step(7'b1111111, 1'b1);
    step(7'h00, 1'b0);
    step(7'h00, 1'b0);
    check("mid_hold_full", obs_ready, 0);
    do_reset("mid");
    step(7'h00, 1'b0);
    check("post_rst_idle", obs_valid, 0);
    step(7'b1011011, 1'b1);
    step(7'h00, 1'b0);
    check("post_rst_first", obs_first, 1);
    check("post_rst_msb", obs_sout, 1);
    for (int i = 0; i < W; i++) step(7'h00, 1'b0);

    // Three idle bit-times between two words
    step(7'b0101010, 1'b1);
    for (int i = 0; i < W; i++) step(7'h00, 1'b0);
    gap = 0;
    step(7'h00, 1'b0); if (!obs_valid) gap++;
    step(7'h00, 1'b0); if (!obs_valid) gap++;
    step(7'b1110001, 1'b1); if (!obs_valid) gap++;
    step(7'h00, 1'b0);
    check("gap_len", gap, 3);
    check("gap_next_first", obs_valid && obs_first, 1);
    for (int i = 0; i < W; i++) step(7'h00, 1'b0);

    // Random traffic with varying offered load and occasional resets
    for (int c = 0; c < 600; c++) begin
      if (c % 200 == 150) do_reset("rand");
      step(7'($urandom), ($urandom_range(0, 9) < (c / 60) % 10 + 1));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/piso_serializer.md
PISO_SERIALIZER -- requirements
Module: piso_serializer

Interface
REQ-001 The block SHALL have parameter WIDTH, default 7, giving the bits per parallel word.
REQ-002 Port clk SHALL be input, 1 bit, the single clock, with all state updated on its rising edge.
REQ-003 Port rst SHALL be input, 1 bit, the asynchronous active-low reset.
REQ-004 Port din SHALL be input, WIDTH bits, the parallel word to serialize MSB-first.
REQ-005 Port din_valid SHALL be input, 1 bit, and indicates that din holds a word to transfer.
REQ-006 Port din_ready SHALL be output, 1 bit, and indicates that the block can accept a word this cycle.
REQ-007 Port sout SHALL be output, 1 bit, the serial bit that drives the downstream sequence detector's serial input.
REQ-008 Port sout_valid SHALL be output, 1 bit, and is high when sout carries a word bit.
REQ-009 Port sout_first SHALL be output, 1 bit, and is high on the MSB cycle of each word.
REQ-010 Port sout_last SHALL be output, 1 bit, and is high on the LSB cycle of each word.
REQ-011 Port busy SHALL be output, 1 bit, and is high whenever a word is shifting or held.

Function
REQ-012 A word SHALL be accepted at a rising edge only when din_valid=1 and din_ready=1, and din SHALL be ignored at all other times.
REQ-013 din_ready SHALL equal rst AND NOT hold_full, computed combinationally from registered state only, with no dependence on din_valid.
REQ-014 The block SHALL implement two states, IDLE and SHIFT, plus a shift register of WIDTH bits, a bit counter of ceil(log2(WIDTH)) bits, and a one-word hold register with a hold_full flag.
REQ-015 In IDLE, an accepted word SHALL load the shifter, clear the counter and move the FSM to SHIFT, so the word's MSB appears on sout in the cycle after the accepting edge (latency 1).
REQ-016 In SHIFT, sout SHALL be the shifter MSB and sout_valid SHALL be 1, with the shifter shifting left by one and the counter incrementing at each edge.
REQ-017 sout_first SHALL be 1 when the counter is 0 and sout_last SHALL be 1 when the counter is WIDTH-1, both only while in SHIFT.
REQ-018 In SHIFT with hold empty, an accepted word SHALL go to the hold register unless the current bit is the last one.
REQ-019 At the last-bit edge with hold_full, the hold word SHALL load into the shifter, hold_full SHALL clear, and the counter SHALL reset to 0.
REQ-020 At the last-bit edge with hold empty and a word accepted on that same edge, din SHALL load directly into the shifter (bypass), leaving hold empty.
REQ-021 At the last-bit edge with hold empty and no acceptance, the FSM SHALL return to IDLE.
REQ-022 Consecutive words SHALL be emitted with zero idle cycles whenever the next word is held or bypassed.
REQ-023 Outside SHIFT, sout, sout_valid, sout_first and sout_last SHALL all be 0.
REQ-024 busy SHALL equal (state==SHIFT) OR hold_full.
REQ-025 For WIDTH=1, sout_first and sout_last SHALL be asserted together on each bit.

Reset
REQ-026 While rst=0, all state SHALL clear asynchronously: FSM=IDLE, shifter=0, counter=0, hold=0, hold_full=0.
REQ-027 While rst=0, every output SHALL be 0, including din_ready.
REQ-028 A reset mid-word SHALL discard the partial word and any held word, with no bit resumed after release.
REQ-029 The first word accepted after reset release SHALL start from its MSB with sout_first=1.

Verification
REQ-030 Reset, then one word 7'b1011010 -> sout=1,0,1,1,0,1,0 on 7 consecutive cycles with sout_valid=1, first on bit 1, last on bit 7, then all outputs 0 and busy=0.
REQ-031 din_valid held high with words 1011010, 1011011, 1011001, 1011000 -> 28 contiguous valid bits in order, and din_ready=0 while the hold is full.
REQ-032 Word A accepted in IDLE, then word B presented only on A's last-bit cycle -> bypass load, B's MSB immediately after A's LSB, and hold_full never set.
REQ-033 din changed while din_ready=0 -> the changes have no effect, and the held word is emitted unchanged.
REQ-034 rst pulled low after 3 bits of 1011010 with a word held -> outputs 0 immediately, and after release the next word 1011011 emits from MSB with no residue.
REQ-035 Two words separated by a 3-cycle din_valid gap -> sout_valid=0 for exactly 3 cycles between the two words' last and first bits.
